// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: alucontrol encodings for the ALU.
package mips_pkg;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_RSV  = 3'b011;
    localparam logic [2:0] ALU_ANDN = 3'b100;
    localparam logic [2:0] ALU_ORN  = 3'b101;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_SLT  = 3'b111;

endpackage

// File: rtl/mips_alu_if.sv
// Operand/result bundle between the MIPS datapath and its ALU.
interface mips_alu_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       F;
    logic [WIDTH-1:0] Y;
    logic             zero;
    logic             cout;
    logic             ovf;
    logic [WIDTH-1:0] y_q;
    logic             zero_q;
    logic             ovf_q;

    modport master (
        output A, B, F,
        input  Y, zero, cout, ovf, y_q, zero_q, ovf_q
    );

    modport slave (
        input  A, B, F,
        output Y, zero, cout, ovf, y_q, zero_q, ovf_q
    );
endinterface

// File: rtl/alu_adder.sv
// WIDTH-bit adder with carry-in, carry-out and two's-complement overflow.
module alu_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_ovf
);
    logic [WIDTH:0] w_s;

    assign w_s    = {1'b0, i_a} + {1'b0, i_b} + {{WIDTH{1'b0}}, i_cin};
    assign o_sum  = w_s[WIDTH-1:0];
    assign o_cout = w_s[WIDTH];
    // Overflow: operands agree in sign but the sum does not.
    assign o_ovf  = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_s[WIDTH-1] != i_a[WIDTH-1]);
endmodule

// File: rtl/mips_alu.sv
// Combinational MIPS ALU with zero/carry/overflow flags plus a registered
// copy of result, zero and overflow for downstream stages and debug.
module mips_alu
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       reset,
    mips_alu_if.slave  alu
);
    logic [WIDTH-1:0] w_bx;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;
    logic             w_ovf;
    logic             w_lt;
    logic [WIDTH-1:0] w_y;
    logic             w_zero;

    logic [WIDTH-1:0] r_y_p0;
    logic             r_zero_p0;
    logic             r_ovf_p0;

    // F[2] turns the adder into a subtractor: A + ~B + 1.
    assign w_bx = alu.F[2] ? ~alu.B : alu.B;

    alu_adder #(.WIDTH(WIDTH)) u_adder (
        .i_a    (alu.A),
        .i_b    (w_bx),
        .i_cin  (alu.F[2]),
        .o_sum  (w_sum),
        .o_cout (w_cout),
        .o_ovf  (w_ovf)
    );

    // Sign of the difference corrected by overflow gives a true signed compare.
    assign w_lt = w_sum[WIDTH-1] ^ w_ovf;

    always_comb begin
        w_y = '0;
        case (alu.F)
            ALU_AND:  w_y = alu.A & alu.B;
            ALU_OR:   w_y = alu.A | alu.B;
            ALU_ADD:  w_y = w_sum;
            ALU_RSV:  w_y = '0;
            ALU_ANDN: w_y = alu.A & w_bx;
            ALU_ORN:  w_y = alu.A | w_bx;
            ALU_SUB:  w_y = w_sum;
            ALU_SLT:  w_y = {{(WIDTH-1){1'b0}}, w_lt};
        endcase
    end

    assign w_zero = (w_y == '0);

    // Stage p0: previous-cycle snapshot of result and flags
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_y_p0    <= '0;
            r_zero_p0 <= 1'b0;
            r_ovf_p0  <= 1'b0;
        end else begin
            r_y_p0    <= w_y;
            r_zero_p0 <= w_zero;
            r_ovf_p0  <= w_ovf;
        end
    end

    assign alu.Y      = w_y;
    assign alu.zero   = w_zero;
    assign alu.cout   = w_cout;
    assign alu.ovf    = w_ovf;
    assign alu.y_q    = r_y_p0;
    assign alu.zero_q = r_zero_p0;
    assign alu.ovf_q  = r_ovf_p0;
endmodule

// File: tb/tb_mips_alu.sv
// Directed-vector scoreboard bench for mips_alu.
module tb_mips_alu;
    import mips_pkg::*;

    localparam int WIDTH = 32;

    logic clk;
    logic reset;

    mips_alu_if #(.WIDTH(WIDTH)) bus ();

    mips_alu #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .alu   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  f;
        logic        rst;
        logic [31:0] y;
        logic        z;
        logic        c;
        logic        o;
    } vec_t;

    typedef struct {
        int          idx;
        logic [31:0] y;
        logic        z;
        logic        c;
        logic        o;
        logic [31:0] yq;
        logic        zq;
        logic        oq;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;
    bit   drv_done = 1'b0;

    task automatic add(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f,
                       input logic rst, input logic [31:0] y, input logic z,
                       input logic c, input logic o);
        vec_t v;
        v.a = a; v.b = b; v.f = f; v.rst = rst;
        v.y = y; v.z = z; v.c = c; v.o = o;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s vec%0d: got %h expected %h", name, idx, act, exp);
    endtask

    // Driver: set inputs just after each edge and record what the edge just latched.
    initial begin
        vec_t prev;
        exp_t e;
        add(32'h0000_0005, 32'h0000_0003, ALU_ADD,  1'b1, 32'h0000_0008, 1'b0, 1'b0, 1'b0);
        add(32'h1234_5678, 32'h1234_5678, ALU_SUB,  1'b1, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
        add(32'h8000_0000, 32'h0000_0001, ALU_SUB,  1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1);
        add(32'hFFFF_FFFF, 32'h0000_0001, ALU_SLT,  1'b1, 32'h0000_0001, 1'b0, 1'b1, 1'b0);
        add(32'h0000_0001, 32'hFFFF_FFFF, ALU_SLT,  1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
        add(32'h7FFF_FFFF, 32'h8000_0000, ALU_SLT,  1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        add(32'hF0F0_F0F0, 32'hFF00_FF00, ALU_AND,  1'b1, 32'hF000_F000, 1'b0, 1'b1, 1'b0);
        add(32'hF0F0_F0F0, 32'hFF00_FF00, ALU_OR,   1'b1, 32'hFFF0_FFF0, 1'b0, 1'b1, 1'b0);
        add(32'hF0F0_F0F0, 32'hFF00_FF00, ALU_ANDN, 1'b1, 32'h00F0_00F0, 1'b0, 1'b0, 1'b0);
        add(32'hF0F0_F0F0, 32'hFF00_FF00, ALU_ORN,  1'b1, 32'hF0FF_F0FF, 1'b0, 1'b0, 1'b0);
        add(32'hF0F0_F0F0, 32'hFF00_FF00, ALU_RSV,  1'b1, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
        add(32'hFFFF_FFFF, 32'h0000_0001, ALU_ADD,  1'b1, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
        add(32'h7FFF_FFFF, 32'h0000_0001, ALU_ADD,  1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
        add(32'h0000_0005, 32'h0000_0003, ALU_ADD,  1'b1, 32'h0000_0008, 1'b0, 1'b0, 1'b0);
        add(32'h0000_0005, 32'h0000_0003, ALU_ADD,  1'b0, 32'h0000_0008, 1'b0, 1'b0, 1'b0);
        add(32'h0000_0005, 32'h0000_0003, ALU_ADD,  1'b1, 32'h0000_0008, 1'b0, 1'b0, 1'b0);
        add(32'h0000_0005, 32'h0000_0003, ALU_ADD,  1'b1, 32'h0000_0008, 1'b0, 1'b0, 1'b0);

        reset  = 1'b0;
        bus.A  = '0;
        bus.B  = '0;
        bus.F  = ALU_AND;
        prev.rst = 1'b0;
        prev.y = '0; prev.z = 1'b0; prev.c = 1'b0; prev.o = 1'b0;
        prev.a = '0; prev.b = '0; prev.f = '0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            bus.A = vecs[i].a;
            bus.B = vecs[i].b;
            bus.F = vecs[i].f;
            reset = vecs[i].rst;
            e.idx = i;
            e.y = vecs[i].y; e.z = vecs[i].z; e.c = vecs[i].c; e.o = vecs[i].o;
            if (!prev.rst) begin
                e.yq = '0; e.zq = 1'b0; e.oq = 1'b0;
            end else begin
                e.yq = prev.y; e.zq = prev.z; e.oq = prev.o;
            end
            sb.push_back(e);
            prev = vecs[i];
        end
        repeat (3) @(posedge clk);
        drv_done = 1'b1;
    end

    // Monitor: outputs are valid every cycle; compare on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("Y",      e.idx, bus.Y,              e.y);
                chk("zero",   e.idx, {31'b0, bus.zero},  {31'b0, e.z});
                chk("cout",   e.idx, {31'b0, bus.cout},  {31'b0, e.c});
                chk("ovf",    e.idx, {31'b0, bus.ovf},   {31'b0, e.o});
                chk("y_q",    e.idx, bus.y_q,            e.yq);
                chk("zero_q", e.idx, {31'b0, bus.zero_q}, {31'b0, e.zq});
                chk("ovf_q",  e.idx, {31'b0, bus.ovf_q},  {31'b0, e.oq});
            end
        end
    end

    initial begin
        int waited;
        waited = 0;
        while (!drv_done && waited < 2000) begin
            @(posedge clk);
            waited++;
        end
        n_total++;
        if (drv_done && sb.size() == 0 && n_total > 100) n_pass++;
        else $display("FAIL drain: done=%0d pending=%0d checks=%0d required done=1 pending=0",
                      drv_done, sb.size(), n_total);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/mips_alu.md
Name: mips_alu

Overview:
- 32-bit integer ALU for the multicycle MIPS datapath.
- Computes the result combinationally from srca/srcb under the 3-bit alucontrol code.
- Drives the zero flag used for beq branch decisions.
- Also provides a registered copy of the result and status flags, so downstream stages and debug can sample the previous cycle's operation.

Parameters:
- WIDTH, 32, operand and result width in bits (≥2).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset: cleared when sampled 0 at a rising clk edge.
- A  in  WIDTH  operand A (srca).
- B  in  WIDTH  operand B (srcb).
- F  in  3  operation select (alucontrol).
- Y  out  WIDTH  combinational result (aluresult).
- zero  out  1  combinational; 1 when Y == 0.
- cout  out  1  combinational carry-out of the internal adder.
- ovf  out  1  combinational signed overflow; meaningful for F=010/110.
- y_q  out  WIDTH  Y registered on clk.
- zero_q  out  1  zero registered on clk.
- ovf_q  out  1  ovf registered on clk.

Behaviour:
- Y, zero, cout and ovf are purely combinational from A, B and F, with zero clock latency. The datapath feeds Y straight to pcnext in the same cycle, so Y must not be registered.
- Internal operand Bx = F[2] ? ~B : B.
- Internal sum S = A + Bx + F[2], computed at WIDTH+1 bits; cout = S[WIDTH].
- Operation decode:
  - 000: Y = A & B.
  - 001: Y = A | B.
  - 010: Y = A + B (wraps mod 2^WIDTH).
  - 011: Y = 0 (reserved code).
  - 100: Y = A & ~B.
  - 101: Y = A | ~B.
  - 110: Y = A − B (wraps).
  - 111: SLT, Y = {0…0, lt}, where lt = S[WIDTH-1] XOR ovf (true signed compare, correct under overflow).
- ovf = (A[msb] == Bx[msb]) && (S[msb] != A[msb]).
  - For logic codes ovf and cout are still driven from the adder; consumers ignore them.
- zero = (Y == 0) for every code, including 011, where zero = 1.
- Register behaviour on each rising clk edge:
  - reset == 0: y_q ← 0, zero_q ← 0, ovf_q ← 0.
  - otherwise: y_q ← Y, zero_q ← zero, ovf_q ← ovf.
  - There is no enable; the registers update every cycle.
- Reset mid-operation affects only the registered outputs; combinational outputs keep following the inputs.
- No X propagation from an unused F code: every code drives defined values.

Decomposition:
- Shared package mips_pkg holds the alucontrol localparams:
  - ALU_AND=3'b000, ALU_OR=3'b001, ALU_ADD=3'b010, ALU_RSV=3'b011
  - ALU_ANDN=3'b100, ALU_ORN=3'b101, ALU_SUB=3'b110, ALU_SLT=3'b111
- One sub-module is natural: alu_adder (WIDTH+1-bit add with carry-in, producing sum, cout, ovf).
- The result mux and flag registers stay in the top level.

Test Plan:
- F=010, A=0x00000005, B=0x00000003 -> Y=0x00000008, zero=0, ovf=0; next edge y_q=0x00000008.
- F=110, A=B=0x12345678 -> Y=0, zero=1, cout=1 (beq-taken case); A=0x80000000, B=1 -> Y=0x7FFFFFFF, ovf=1.
- F=111:
  - A=0xFFFFFFFF, B=1 -> Y=1.
  - A=1, B=0xFFFFFFFF -> Y=0, zero=1.
  - A=0x7FFFFFFF, B=0x80000000 -> Y=0 (overflow-corrected).
- Logic ops with A=0xF0F0F0F0, B=0xFF00FF00:
  - 000 -> 0xF000F000
  - 001 -> 0xFFF0FFF0
  - 100 -> 0x00F000F0
  - 101 -> 0xF0FFF0FF
  - 011 -> 0x00000000 with zero=1.
- Wrap: F=010, A=0xFFFFFFFF, B=1 -> Y=0, zero=1, cout=1, ovf=0.
- Reset: hold reset=0 across an edge while Y=0x8 -> y_q=0, zero_q=0, ovf_q=0 while Y still reads 0x8; release reset -> y_q=0x8 after the next edge.
